// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] a, b, ua, ub, q, r, hi_n, lo_n;
  logic [63:0] prod;
  logic sgn, accept, fin, is_mul, is_div;
  always_comb begin
    accept = start && state == IDLE && op inside {[3'd1:3'd6]};
    is_mul = accept && op inside {3'd1, 3'd2};
    is_div = accept && op inside {3'd3, 3'd4};
    fin = state != IDLE && cnt == CW'(1);
    prod = (sgn ? {{32{a[31]}}, a} : {32'b0, a}) * (sgn ? {{32{b[31]}}, b} : {32'b0, b});
    // Signed division via magnitudes: also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow
    ua = sgn && a[31] ? -a : a;
    ub = sgn && b[31] ? -b : b;
    q = ub == '0 ? '0 : ua / ub;
    r = ub == '0 ? '0 : ua % ub;
    state_n = fin ? IDLE : is_mul ? MUL : is_div ? DIV : state;
    cnt_n = state != IDLE ? cnt - CW'(1) : is_mul ? CW'(MULT_CYCLES) : is_div ? CW'(DIV_CYCLES) : cnt;
    hi_n = accept && op == 3'd5 ? rs_data :
           fin && state == MUL ? prod[63:32] :
           fin && state == DIV && b != '0 ? (sgn && a[31] ? -r : r) : hi;
    lo_n = accept && op == 3'd6 ? rs_data :
           fin && state == MUL ? prod[31:0] :
           fin && state == DIV && b != '0 ? (sgn && (a[31] ^ b[31]) ? -q : q) : lo;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      a     <= '0;
      b     <= '0;
      sgn   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= state_n != IDLE;
      done  <= fin;
      hi    <= hi_n;
      lo    <= lo_n;
      if (accept) begin
        a   <= rs_data;
        b   <= rt_data;
        sgn <= op == 3'd1 || op == 3'd3;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed check of md_unit against an arithmetic reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] rs = '0, rt = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_data(rs), .rt_data(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int q, r;
    if (o == 3'd1) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (o == 3'd2) return {32'b0, x} * {32'b0, y};
    if (y == 0) return 64'd0;
    if (o == 3'd4) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic m_busy = 1'b0, m_done = 1'b0, pend_ok = 1'b0;
  logic [63:0] pend = '0;
  int rem = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (pend_ok) {m_hi, m_lo} <= pend;
        end
      end else if (start && op >= 3'd1 && op <= 3'd6) begin
        if (op == 3'd5) m_hi <= rs;
        else if (op == 3'd6) m_lo <= rs;
        else begin
          rem <= op <= 3'd2 ? MC : DC;
          m_busy <= 1'b1;
          pend <= model_result(op, rs, rt);
          pend_ok <= !(op >= 3'd3 && rt == 0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_hi", hi, m_hi);
    chk("model_lo", lo, m_lo);
    chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
    chk("model_done", {31'b0, done}, {31'b0, m_done});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rs = $urandom;
      rt = $urandom;
      tick();
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; rs = x; rt = y;
    tick();
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      idle(1);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=timeout expected=done within %0d cycles", limit);
    end
  endtask

  int n;
  logic [2:0] o;
  logic [31:0] x, y;

  initial begin
    #3 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    issue(3'd5, 32'hDEAD, 32'h0);
    chk("mthi_hi", hi, 32'hDEAD);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd6, 32'hBEEF, 32'h0);
    chk("mtlo_lo", lo, 32'hBEEF);
    chk("mtlo_hi", hi, 32'hDEAD);

    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    idle(MC - 1);
    chk("mult_busy_last", {31'b0, busy}, 32'h1);
    chk("mult_hi_hold", hi, 32'hDEAD);
    idle(1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_done", {31'b0, done}, 32'h1);
    chk("mult_busy_low", {31'b0, busy}, 32'h0);
    idle(1);
    chk("mult_done_once", {31'b0, done}, 32'h0);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd1, 32'd7, 32'd9);
    wait_done(20, n);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    idle(2);
    chk("ignored_busy", {31'b0, busy}, 32'h0);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(20, n);
    chk("div_latency", n, DC);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    idle(1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    wait_done(20, n);
    chk("divu_lo", lo, 32'h7FFFFFFC);
    chk("divu_hi", hi, 32'h00000001);
    idle(1);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(20, n);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);
    idle(1);

    issue(3'd5, 32'h11, 32'h0);
    issue(3'd6, 32'h22, 32'h0);
    issue(3'd3, 32'h1234, 32'h0);
    wait_done(20, n);
    chk("div0_latency", n, DC);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    idle(1);
    issue(3'd7, 32'h99, 32'h5);
    chk("op7_hi", hi, 32'h11);
    chk("op7_busy", {31'b0, busy}, 32'h0);

    issue(3'd3, 32'd1000, 32'd7);
    idle(6);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_done", {31'b0, done}, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(DC + 2);
    chk("rst_no_commit_hi", hi, 32'h0);
    chk("rst_no_commit_lo", lo, 32'h0);

    for (int i = 0; i < 600; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) issue(o, x, y);
      else idle(1);
    end
    idle(DC + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit sitting beside the execute stage of the five-stage pipelined CPU; it owns the HI/LO register pair. It accepts mult/multu/div/divu/mthi/mtlo commands from the execute stage and computes the products and quotients over a fixed multi-cycle latency. It exposes `busy` so decode-stage hazard logic can stall. It drives HI/LO to the execute stage for mfhi/mflo.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for mult/multu (≥1).
- `DIV_CYCLES`, 10: cycles `busy` stays high for div/divu (≥1).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low.
- `start`  in  1  command valid for the current cycle.
- `op`  in  3  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- `rs_data`  in  32  operand A (dividend / multiplicand / mthi-mtlo source).
- `rt_data`  in  32  operand B (divisor / multiplier).
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO commit from mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV. Internal down-counter `cnt`, operand/result latches.
- Accept rule: a command is accepted on an edge only if `start`=1, state IDLE, and `op` ∈ 1..6. `start` while busy, or `op` 0/7, is ignored with no state change. Upstream must stall rather than rely on queuing.
- mthi/mtlo: on the accepting edge, `hi`←`rs_data` (mthi) or `lo`←`rs_data` (mtlo). No busy, no done. The other register is untouched.
- mult/multu: at the accepting edge, latch operands and go to MUL with `cnt`←MULT_CYCLES. The 64-bit product is signed (mult) or unsigned (multu), with {hi,lo}←product.
- div/divu: at the accepting edge, go to DIV with `cnt`←DIV_CYCLES. Signed division truncates toward zero, and the remainder takes the sign of the dividend. lo←quotient, hi←remainder.
- Division special cases:
  - Divisor 0: hi/lo left unchanged at completion. Busy and done still behave normally.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- In MUL/DIV, each edge decrements `cnt`. On the edge where `cnt`=1, commit hi/lo, return to IDLE, and set `done`=1 for the following cycle.
- Operands are latched at accept; later changes on `rs_data`/`rt_data` have no effect.
- Reset low at any time, including mid-operation: state IDLE, cnt=0, busy=0, done=0, hi=0, lo=0. The in-flight result is discarded.

## Timing
- `busy` is registered. For an operation accepted at edge E, `busy`=1 from just after E through exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). It falls at edge E+N.
- hi/lo are registered. New mult/div values are visible just after edge E+N, and old values hold through edge E+N.
- `done`=1 for the single cycle between edges E+N and E+N+1.
- A new command may be accepted at edge E+N+1 at the earliest, since `busy` is still 1 when sampled at E+N.
- mthi/mtlo take effect immediately after the accepting edge and have zero added latency.
- Decode hazard logic must stall any md-class instruction, including mfhi/mflo, while `start`=1 or `busy`=1.
- hi/lo outputs are combinational from registers only; there is no input-to-output combinational path.

## Test plan
- Reset: drive `reset`=0 mid-DIV (cnt=4) → busy, done, hi and lo all go to 0 immediately. After release, the block idles with no late commit.
- mult signed: rs=0xFFFFFFFE (−2), rt=3 at edge E → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA after E+5. done pulses once.
- multu: rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Change rs/rt during busy → result unchanged.
- div: rs=−7 (0xFFFFFFF9), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same operands with divu → lo=0x7FFFFFFC, hi=0x00000001.
- Edge cases:
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - div by 0 with prior hi=0x11, lo=0x22 → unchanged, busy 10 cycles, done pulses.
- Command handling:
  - mthi 0xDEAD then mtlo 0xBEEF on consecutive edges → hi/lo update one cycle each, busy stays 0.
  - start with mult while busy → ignored, result equals the first operation.
  - op=7 → no change.
